// File: rtl/mp_add_pkg.sv
// Shared types for the multi-precision add/subtract sequencer.
package mp_add_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/mp_add_out_reg.sv
// One-entry valid/ready output register for sum words; latency 1 cycle.
// A load overrides the drain, so a word can enter and leave in the same cycle.
module mp_add_out_reg
  import mp_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_sum,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_sum   <= load_sum;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mp_add_sequencer.sv
// Chains an external 32-bit adder over len words, LSW first; 1-cycle latency, 1 word/cycle.
// in_ready drops while the output word is stalled. MP_ADD_SEQ_OVERFLOW_EN adds the overflow port.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int MAX_WORDS = 8,
  parameter int LEN_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              sub,
  output logic              busy,
  output logic              err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              carry_out,
  output logic              done,
  output logic [WORD_W-1:0] adder_a,
  output logic [WORD_W-1:0] adder_b,
  output logic              adder_cin,
  input  logic [WORD_W-1:0] adder_sum,
  input  logic [WORD_W-1:0] adder_cout
`ifdef MP_ADD_SEQ_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);

  state_t           state;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic             carry_r;
  logic             sub_r;
  logic             len_bad;
  logic             start_ok;
  logic             in_hs;
  logic             is_last;
  logic             drain_fin;
  logic             unused_cout;

  assign len_bad   = (len == '0) || (len > LEN_W'(MAX_WORDS));
  assign start_ok  = (state == IDLE) && start && !len_bad;
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign in_hs     = in_valid && in_ready;
  assign is_last   = (cnt == len_r - LEN_W'(1));
  assign drain_fin = (state == DRAIN) && out_valid && out_ready && out_last;
  assign busy      = (state != IDLE);

  // Subtraction is A + ~B + 1; the +1 comes from seeding the carry with sub.
  assign adder_a   = in_a;
  assign adder_b   = sub_r ? ~in_b : in_b;
  assign adder_cin = carry_r;

  // Only the top carries matter; the rest of the adder's carry vector is ignored.
  assign unused_cout = ^adder_cout[30:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      err       <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      carry_r   <= 1'b0;
      sub_r     <= 1'b0;
      len_r     <= '0;
      cnt       <= '0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && len_bad) begin
            err <= 1'b1;
          end else if (start_ok) begin
            len_r     <= len;
            sub_r     <= sub;
            carry_r   <= sub;
            cnt       <= '0;
            carry_out <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (in_hs) begin
            carry_r <= adder_cout[WORD_W-1];
            cnt     <= cnt + LEN_W'(1);
            if (is_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_fin) begin
            carry_out <= carry_r;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MP_ADD_SEQ_OVERFLOW_EN
  logic ovf_r;

  // Captured on the last word, published together with carry_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (start_ok) overflow <= 1'b0;
      else if (drain_fin) overflow <= ovf_r;
      if (state == RUN && in_hs && is_last)
        ovf_r <= adder_cout[WORD_W-1] ^ adder_cout[WORD_W-2];
    end
  end
`endif

  mp_add_out_reg u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (in_hs),
    .load_sum  (adder_sum),
    .load_last (is_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer with a behavioural ripple adder on the adder_* ports.
module tb_mp_add_sequencer;
  import mp_add_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic        sub;
  logic        busy, err;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic        out_last, carry_out, done;
  logic [31:0] adder_a, adder_b, adder_sum, adder_cout;
  logic        adder_cin;
`ifdef MP_ADD_SEQ_OVERFLOW_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  word_t va [8];
  word_t vb [8];
  word_t got_sum [8];
  logic  got_last [8];
  int    got_n, done_cyc, last_hs_cyc, bp_viol;
  logic  carry_seen, timed_out;

  always #5 clk = ~clk;

  // External adder: per-bit ripple carries, bit 31 is the word carry.
  always_comb begin
    logic c;
    c = adder_cin;
    adder_cout = '0;
    for (int i = 0; i < 32; i++) begin
      adder_cout[i] = (adder_a[i] & adder_b[i]) | (c & (adder_a[i] ^ adder_b[i]));
      c = adder_cout[i];
    end
    adder_sum = adder_a + adder_b + {31'd0, adder_cin};
  end

  mp_add_sequencer #(.MAX_WORDS(8), .LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .sub        (sub),
    .busy       (busy),
    .err        (err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_last   (out_last),
    .carry_out  (carry_out),
    .done       (done),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout)
`ifdef MP_ADD_SEQ_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from va/vb, recording output words; out_ready follows rpat cyclically.
  task automatic run_op(input int n, input logic s, input logic [7:0] rpat);
    int idx;
    int nout;
    logic fin;
    idx = 0; nout = 0; fin = 1'b0;
    done_cyc = -1; last_hs_cyc = -1; bp_viol = 0; carry_seen = 1'b0;
    start = 1'b1; len = n[3:0]; sub = s;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      in_valid  = (idx < n);
      in_a      = va[idx % 8];
      in_b      = vb[idx % 8];
      out_ready = rpat[cyc % 8];
      #1;
      if (done) begin
        done_cyc = cyc; carry_seen = carry_out; fin = 1'b1;
      end
      if (out_valid && !out_ready && in_ready) bp_viol++;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (nout < 8) begin
          got_sum[nout]  = out_sum;
          got_last[nout] = out_last;
        end
        nout++;
        last_hs_cyc = cyc;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    got_n = nout;
    timed_out = !fin;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; len = '0; sub = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/err/in_ready/done=%b%b%b%b expected 0000", busy, err, in_ready, done);
    end
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_last !== 1'b0 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b sum=%h last=%b carry=%b expected all zero", out_valid, out_sum, out_last, carry_out);
    end
  endtask

  task automatic test_add2;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'h00000001;
    va[1] = 32'h00000001; vb[1] = 32'h00000000;
    run_op(2, 1'b0, 8'hFF);
    checks++;
    if (timed_out !== 1'b0 || got_n !== 2) begin
      errors++; $display("FAIL add2_count: words=%0d timeout=%b expected 2 words, no timeout", got_n, timed_out);
    end
    checks++;
    if (got_sum[0] !== 32'h00000000 || got_sum[1] !== 32'h00000002) begin
      errors++; $display("FAIL add2_sum: got %h_%h expected 00000002_00000000", got_sum[1], got_sum[0]);
    end
    checks++;
    if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
      errors++; $display("FAIL add2_last: got %b%b expected 10", got_last[1], got_last[0]);
    end
    checks++;
    if (carry_seen !== 1'b0) begin
      errors++; $display("FAIL add2_carry: got %b expected 0", carry_seen);
    end
    checks++;
    if (done_cyc !== last_hs_cyc + 1) begin
      errors++; $display("FAIL add2_done_timing: done at %0d expected %0d", done_cyc, last_hs_cyc + 1);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL add2_idle: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_add1;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF;
    run_op(1, 1'b0, 8'hFF);
    checks++;
    if (got_n !== 1 || got_sum[0] !== 32'hFFFFFFFE || got_last[0] !== 1'b1) begin
      errors++; $display("FAIL add1_word: n=%0d sum=%h last=%b expected 1 fffffffe 1", got_n, got_sum[0], got_last[0]);
    end
    checks++;
    if (carry_seen !== 1'b1 || carry_out !== 1'b1) begin
      errors++; $display("FAIL add1_carry: got %b/%b expected 1", carry_seen, carry_out);
    end
  endtask

  task automatic test_sub3;
    va[0] = 32'h5; vb[0] = 32'h7;
    va[1] = 32'h0; vb[1] = 32'h0;
    va[2] = 32'h0; vb[2] = 32'h0;
    run_op(3, 1'b1, 8'hFF);
    checks++;
    if (got_n !== 3 || got_sum[0] !== 32'hFFFFFFFE || got_sum[1] !== 32'hFFFFFFFF || got_sum[2] !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL sub3_sum: n=%0d got %h_%h_%h expected ffffffff_ffffffff_fffffffe", got_n, got_sum[2], got_sum[1], got_sum[0]);
    end
    checks++;
    if (carry_seen !== 1'b0 || got_last[2] !== 1'b1) begin
      errors++; $display("FAIL sub3_borrow: carry=%b last=%b expected 0 1", carry_seen, got_last[2]);
    end
  endtask

  task automatic test_backpressure;
    va[0] = 32'h80000000; vb[0] = 32'h80000000;
    va[1] = 32'hFFFFFFFF; vb[1] = 32'h00000001;
    va[2] = 32'h12345678; vb[2] = 32'hEDCBA987;
    va[3] = 32'h00000000; vb[3] = 32'h00000005;
    run_op(4, 1'b0, 8'b1001_1001);
    checks++;
    if (bp_viol !== 0) begin
      errors++; $display("FAIL bp_in_ready: violations=%0d expected 0", bp_viol);
    end
    checks++;
    if (got_n !== 4 || timed_out !== 1'b0) begin
      errors++; $display("FAIL bp_count: words=%0d timeout=%b expected 4 no timeout", got_n, timed_out);
    end
    checks++;
    if (got_sum[0] !== 32'h0 || got_sum[1] !== 32'h1 || got_sum[2] !== 32'h0 || got_sum[3] !== 32'h6) begin
      errors++; $display("FAIL bp_sum: got %h_%h_%h_%h expected 00000006_00000000_00000001_00000000", got_sum[3], got_sum[2], got_sum[1], got_sum[0]);
    end
    checks++;
    if (carry_seen !== 1'b0 || got_last[3] !== 1'b1 || got_last[2] !== 1'b0) begin
      errors++; $display("FAIL bp_tail: carry=%b last3=%b last2=%b expected 0 1 0", carry_seen, got_last[3], got_last[2]);
    end
  endtask

  task automatic test_err;
    int nout;
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_len0: err=%b busy=%b expected 1 0", err, busy);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_pulse: err=%b expected 0", err);
    end
    start = 1'b1; len = 4'd9;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_len9: err=%b busy=%b expected 1 0", err, busy);
    end
    // Start with len=2, then a second start while busy that must be ignored.
    start = 1'b1; len = 4'd2; sub = 1'b0;
    tick();
    len = 4'd0;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL err_busy_start: err=%b busy=%b expected 0 1", err, busy);
    end
    in_valid = 1'b1; in_a = 32'h1; in_b = 32'h1; out_ready = 1'b1;
    nout = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid && out_ready) nout++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (nout !== 2 || busy !== 1'b0) begin
      errors++; $display("FAIL err_ignored_len: words=%0d busy=%b expected 2 0", nout, busy);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) begin va[i] = 32'hA0 + i; vb[i] = 32'h1; end
    start = 1'b1; len = 4'd4; sub = 1'b0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_a = va[0]; in_b = vb[0]; out_ready = 1'b1;
    tick();
    in_a = va[1]; in_b = vb[1];
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'h0 || out_last !== 1'b0 || carry_out !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid: busy=%b rdy=%b vld=%b sum=%h last=%b carry=%b done=%b expected all zero",
                         busy, in_ready, out_valid, out_sum, out_last, carry_out, done);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    va[0] = 32'h3; vb[0] = 32'h4;
    run_op(1, 1'b0, 8'hFF);
    checks++;
    if (got_n !== 1 || got_sum[0] !== 32'h7 || got_last[0] !== 1'b1 || carry_seen !== 1'b0) begin
      errors++; $display("FAIL rst_recover: n=%0d sum=%h last=%b carry=%b expected 1 00000007 1 0", got_n, got_sum[0], got_last[0], carry_seen);
    end
  endtask

`ifdef MP_ADD_SEQ_OVERFLOW_EN
  task automatic test_overflow;
    va[0] = 32'h7FFFFFFF; vb[0] = 32'h00000001;
    run_op(1, 1'b0, 8'hFF);
    checks++;
    if (overflow !== 1'b1 || carry_seen !== 1'b0 || got_sum[0] !== 32'h80000000) begin
      errors++; $display("FAIL ovf: overflow=%b carry=%b sum=%h expected 1 0 80000000", overflow, carry_seen, got_sum[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add2();
    test_add1();
    test_sub3();
    test_backpressure();
    test_err();
    test_reset_mid();
`ifdef MP_ADD_SEQ_OVERFLOW_EN
    test_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
